register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 85 ++++++++
 tb/tb_register_file.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32x32 register file with two combinational read ports and EX/MEM/WB bypassing.
// Bypass priority is EX, then MEM, then WB write-through, then the stored array.
module register_file #(
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_register_write_enable,
  input  logic [4:0]  ex_register_write_address,
  input  logic [31:0] ex_register_write_data,
  input  logic        mem_register_write_enable,
  input  logic [4:0]  mem_register_write_address,
  input  logic [31:0] mem_register_write_data,
  input  logic        wb_register_write_enable,
  input  logic [4:0]  wb_register_write_address,
  input  logic [31:0] wb_register_write_data,
  input  logic        read_enable_1,
  input  logic [4:0]  read_address_1,
  input  logic        read_enable_2,
  input  logic [4:0]  read_address_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic        read_forwarded_1,
  output logic        read_forwarded_2
);

  logic [31:0] entries [32];

  logic        read_enable  [2];
  logic [4:0]  read_address [2];
  logic [31:0] read_data    [2];
  logic        read_forwarded [2];

  assign read_enable[0]  = read_enable_1;
  assign read_enable[1]  = read_enable_2;
  assign read_address[0] = read_address_1;
  assign read_address[1] = read_address_2;

  assign read_data_1      = read_data[0];
  assign read_data_2      = read_data[1];
  assign read_forwarded_1 = read_forwarded[0];
  assign read_forwarded_2 = read_forwarded[1];

  // NOTE: the array is reset, so it builds from flops with async clear rather
  // than a RAM macro; this is what lets reset discard every value at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        entries[i] <= '0;
      end
    end else if (wb_register_write_enable &&
                 !(ZERO_HARDWIRED && wb_register_write_address == 5'd0)) begin
      entries[wb_register_write_address] <= wb_register_write_data;
    end
  end

  // NOTE: outputs get defaults before any branch so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      read_data[p]      = '0;
      read_forwarded[p] = 1'b0;
      if (reset && read_enable[p] &&
          !(ZERO_HARDWIRED && read_address[p] == 5'd0)) begin
        if (ex_register_write_enable &&
            ex_register_write_address == read_address[p]) begin
          read_data[p]      = ex_register_write_data;
          read_forwarded[p] = 1'b1;
        end else if (mem_register_write_enable &&
                     mem_register_write_address == read_address[p]) begin
          read_data[p]      = mem_register_write_data;
          read_forwarded[p] = 1'b1;
        end else if (wb_register_write_enable &&
                     wb_register_write_address == read_address[p]) begin
          // Same-cycle write-through: the value lands in the array at the edge.
          read_data[p]      = wb_register_write_data;
          read_forwarded[p] = 1'b1;
        end else begin
          read_data[p] = entries[read_address[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read results are queued as
// stimulus is applied and compared once the combinational outputs settle.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_en, mem_en, wb_en;
  logic [4:0]  ex_addr, mem_addr, wb_addr;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        re1, re2;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, rd1_nz, rd2_nz;
  logic        rf1, rf2, rf1_nz, rf2_nz;

  register_file dut (
    .clock(clock), .reset(reset),
    .ex_register_write_enable(ex_en), .ex_register_write_address(ex_addr),
    .ex_register_write_data(ex_data),
    .mem_register_write_enable(mem_en), .mem_register_write_address(mem_addr),
    .mem_register_write_data(mem_data),
    .wb_register_write_enable(wb_en), .wb_register_write_address(wb_addr),
    .wb_register_write_data(wb_data),
    .read_enable_1(re1), .read_address_1(ra1),
    .read_enable_2(re2), .read_address_2(ra2),
    .read_data_1(rd1), .read_data_2(rd2),
    .read_forwarded_1(rf1), .read_forwarded_2(rf2)
  );

  // Second instance with register 0 as an ordinary register.
  register_file #(.ZERO_HARDWIRED(1'b0)) dut_nz (
    .clock(clock), .reset(reset),
    .ex_register_write_enable(ex_en), .ex_register_write_address(ex_addr),
    .ex_register_write_data(ex_data),
    .mem_register_write_enable(mem_en), .mem_register_write_address(mem_addr),
    .mem_register_write_data(mem_data),
    .wb_register_write_enable(wb_en), .wb_register_write_address(wb_addr),
    .wb_register_write_data(wb_data),
    .read_enable_1(re1), .read_address_1(ra1),
    .read_enable_2(re2), .read_address_2(ra2),
    .read_data_1(rd1_nz), .read_data_2(rd2_nz),
    .read_forwarded_1(rf1_nz), .read_forwarded_2(rf2_nz)
  );

  always #50 clock = ~clock;

  typedef struct {
    string       tag;
    int          port;   // 1/2 = main DUT ports, 3/4 = non-hardwired DUT ports
    logic [31:0] data;
    logic        fwd;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] model [32];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expect_port(input string tag, input int port,
                             input logic [31:0] data, input logic fwd);
    exp_t e;
    e.tag = tag; e.port = port; e.data = data; e.fwd = fwd;
    sb.push_back(e);
  endtask

  task automatic compare_outputs(input int settle);
    exp_t        e;
    logic [31:0] d;
    logic        f;
    #settle;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        1:       begin d = rd1;    f = rf1;    end
        2:       begin d = rd2;    f = rf2;    end
        3:       begin d = rd1_nz; f = rf1_nz; end
        default: begin d = rd2_nz; f = rf2_nz; end
      endcase
      check({e.tag, ".data"}, d, e.data);
      check({e.tag, ".fwd"}, {31'b0, f}, {31'b0, e.fwd});
    end
  endtask

  task automatic idle_writes();
    ex_en = 1'b0; mem_en = 1'b0; wb_en = 1'b0;
    ex_addr = '0; mem_addr = '0; wb_addr = '0;
    ex_data = '0; mem_data = '0; wb_data = '0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    idle_writes();
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clock);
    @(negedge clock);
    wb_en = 1'b0;
  endtask

  function automatic logic [32:0] model_read(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0)                return 33'd0;
    if (ex_en && ex_addr == a)           return {1'b1, ex_data};
    if (mem_en && mem_addr == a)         return {1'b1, mem_data};
    if (wb_en && wb_addr == a)           return {1'b1, wb_data};
    return {1'b0, model[a]};
  endfunction

  initial begin
    logic [32:0] r;
    reset = 1'b0;
    idle_writes();
    re1 = 1'b0; re2 = 1'b0; ra1 = '0; ra2 = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Outputs held at zero during reset even with an active bypass match.
    @(negedge clock);
    ex_en = 1'b1; ex_addr = 5'd4; ex_data = 32'hCAFE_F00D;
    re1 = 1'b1; ra1 = 5'd4; re2 = 1'b1; ra2 = 5'd4;
    expect_port("in_reset_p1", 1, 32'h0, 1'b0);
    expect_port("in_reset_p2", 2, 32'h0, 1'b0);
    compare_outputs(1);
    idle_writes();
    @(negedge clock);
    reset = 1'b1;

    // Every address reads zero on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a);
      expect_port($sformatf("reset_r%0d_p1", a), 1, 32'h0, 1'b0);
      expect_port($sformatf("reset_r%0d_p2", a), 2, 32'h0, 1'b0);
      compare_outputs(1);
    end

    // Plain write then array read; r0 write dropped when hardwired.
    wb_write(5'd5, 32'h1234_5678);
    model[5] = 32'h1234_5678;
    ra1 = 5'd5;
    expect_port("r5_array", 1, 32'h1234_5678, 1'b0);
    compare_outputs(1);

    @(negedge clock);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    ra1 = 5'd0; ra2 = 5'd0;
    expect_port("r0_wt_hw", 1, 32'h0, 1'b0);
    expect_port("r0_wt_nz", 3, 32'hFFFF_FFFF, 1'b1);
    compare_outputs(1);
    @(posedge clock);
    @(negedge clock);
    wb_en = 1'b0;
    expect_port("r0_after_hw", 1, 32'h0, 1'b0);
    expect_port("r0_after_nz", 3, 32'hFFFF_FFFF, 1'b0);
    expect_port("r0_after_nz_p2", 4, 32'hFFFF_FFFF, 1'b0);
    compare_outputs(1);

    // Bypass priority on r7, all steps inside one low clock phase.
    wb_write(5'd7, 32'h1);
    model[7] = 32'h1;
    ra1 = 5'd7; ra2 = 5'd7;
    ex_en = 1'b1;  ex_addr = 5'd7;  ex_data = 32'hA;
    mem_en = 1'b1; mem_addr = 5'd7; mem_data = 32'hB;
    wb_en = 1'b1;  wb_addr = 5'd7;  wb_data = 32'hC;
    expect_port("prio_ex_p1", 1, 32'hA, 1'b1);
    expect_port("prio_ex_p2", 2, 32'hA, 1'b1);
    compare_outputs(1);
    ex_en = 1'b0;
    expect_port("prio_mem_p1", 1, 32'hB, 1'b1);
    expect_port("prio_mem_p2", 2, 32'hB, 1'b1);
    compare_outputs(1);
    mem_en = 1'b0;
    expect_port("prio_wb_p1", 1, 32'hC, 1'b1);
    expect_port("prio_wb_p2", 2, 32'hC, 1'b1);
    compare_outputs(1);
    wb_en = 1'b0;
    expect_port("prio_arr_p1", 1, 32'h1, 1'b0);
    expect_port("prio_arr_p2", 2, 32'h1, 1'b0);
    compare_outputs(1);

    // Write-through before the edge, array after it.
    @(negedge clock);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55; ra1 = 5'd3;
    expect_port("wt_r3_before", 1, 32'h55, 1'b1);
    compare_outputs(1);
    @(posedge clock);
    @(negedge clock);
    wb_en = 1'b0;
    model[3] = 32'h55;
    expect_port("wt_r3_after", 1, 32'h55, 1'b0);
    compare_outputs(1);

    // Disabled port 2 ignores a MEM match; port 1 still bypasses.
    mem_en = 1'b1; mem_addr = 5'd9; mem_data = 32'h9999_0000;
    re2 = 1'b0; ra2 = 5'd9; ra1 = 5'd9;
    expect_port("ren2_off_p2", 2, 32'h0, 1'b0);
    expect_port("ren2_off_p1", 1, 32'h9999_0000, 1'b1);
    compare_outputs(1);
    idle_writes();
    re2 = 1'b1;

    // Random traffic over a small address range so bypass hits are frequent.
    for (int it = 0; it < 60; it++) begin
      @(negedge clock);
      ex_en  = ($urandom_range(0, 2) == 0); ex_addr  = 5'($urandom_range(0, 7)); ex_data  = $urandom;
      mem_en = ($urandom_range(0, 2) == 0); mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
      wb_en  = ($urandom_range(0, 1) == 0); wb_addr  = 5'($urandom_range(0, 7)); wb_data  = $urandom;
      re1 = ($urandom_range(0, 3) != 0); ra1 = 5'($urandom_range(0, 7));
      re2 = ($urandom_range(0, 3) != 0); ra2 = 5'($urandom_range(0, 7));
      r = model_read(re1, ra1);
      expect_port($sformatf("rand%0d_p1", it), 1, r[31:0], r[32]);
      r = model_read(re2, ra2);
      expect_port($sformatf("rand%0d_p2", it), 2, r[31:0], r[32]);
      compare_outputs(1);
      @(posedge clock);
      if (wb_en && wb_addr != 5'd0) model[wb_addr] = wb_data;
    end
    @(negedge clock);
    idle_writes();
    re1 = 1'b1; re2 = 1'b1;

    // Fill r1..r31, then a short reset pulse with no clock edge inside it.
    for (int a = 1; a < 32; a++) wb_write(5'(a), 32'(a));
    ra1 = 5'd17;
    expect_port("filled_r17", 1, 32'd17, 1'b0);
    compare_outputs(1);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      expect_port($sformatf("midrst_r%0d", a), 1, 32'h0, 1'b0);
      expect_port($sformatf("midrst_r%0d_p2", 31 - a), 2, 32'h0, 1'b0);
      compare_outputs(1);
    end

    // A write presented while reset is held through the edge is dropped.
    @(negedge clock);
    reset = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hDEAD_BEEF;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    wb_en = 1'b0;
    ra1 = 5'd10;
    expect_port("rst_wr_dropped", 1, 32'h0, 1'b0);
    compare_outputs(1);
    wb_write(5'd10, 32'hDEAD_BEEF);
    expect_port("post_rst_write", 1, 32'hDEAD_BEEF, 1'b0);
    compare_outputs(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
